pid_regfile: RTL and testbench
==============================

Name: pid_regfile

Overview:
- Parametrised register bank for the PID datapath.
- Provides N general-purpose data registers, two combinational read ports and one write port with optional same-cycle bypass.
- Sample-and-hold shadows for the external inputs (reference, potentiometer) keep operands stable for a whole control iteration.
- A double-buffered PWM output register is updated only on an explicit commit.
- Sits between the sequencer/ALU and the PWM generator.

Parameters:
- DATA_W, 18, datapath word width.
- ADDR_W, 4, address width of all read and write ports.
- NUM_EXT, 2, number of external input channels, mapped at addresses 1..NUM_EXT.
- NUM_GP, 8, number of general-purpose registers, mapped at addresses NUM_EXT+1..NUM_EXT+NUM_GP.
- PWM_IDX, 7, GP index (0-based) whose value feeds the PWM buffer.
- BYPASS, 1, 1 = read ports forward same-cycle write data.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- ext_in  in  NUM_EXT*DATA_W  external channels; channel k occupies bits [k*DATA_W +: DATA_W].
- sample  in  1  capture all ext_in into shadows.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  read port A data, combinational.
- rd_data_b  out  DATA_W  read port B data, combinational.
- commit  in  1  transfer GP[PWM_IDX] to pwm_out.
- pwm_out  out  DATA_W  buffered PWM word.
- pwm_valid  out  1  set after first commit.
- wr_err  out  1  one-cycle pulse: write to a non-writable address.

Behaviour:
- Reset:
  - Reset is synchronous: it acts only on the clk edge when rst=0.
  - Clears all GP registers, ext shadows, pwm_out, pwm_valid and wr_err.
  - Reset overrides every simultaneous input.
  - A reset mid-iteration discards all pending state; there is no partial commit.
- Address map, default parameters:
  - 0 reads constant 0.
  - 1..2 read ext shadows.
  - 3..10 read GP0..GP7.
  - 11..15 read 0.
  - The map is generated from the parameters. Elaboration must fail if NUM_EXT+NUM_GP+1 > 2^ADDR_W or PWM_IDX >= NUM_GP.
- Write:
  - On a clk edge with wr_en=1 and wr_addr in the GP range, GP[wr_addr-(NUM_EXT+1)] takes wr_data.
  - With wr_en=1 and wr_addr outside the GP range (0, ext, or unmapped), the write is dropped and wr_err=1 the following cycle, for one cycle.
- Read:
  - Combinational from the registered state, 0 cycles latency.
  - If BYPASS=1, wr_en=1 and rd_addr equals wr_addr in the GP range, the port returns wr_data in the same cycle.
  - Both ports bypass independently.
  - There is no bypass for ext addresses or for the sample path.
- Sample:
  - On a clk edge with sample=1, every shadow takes its ext_in slice.
  - A read in the same cycle returns the old shadow value.
- Commit:
  - On a clk edge with commit=1, pwm_out takes the registered GP[PWM_IDX] (the pre-edge value, never the bypassed wr_data) and pwm_valid is set.
  - pwm_valid stays 1 until reset.
  - A write to the PWM register in the same cycle as commit lands in GP only; the next commit carries it.
- Simultaneous sample, write and commit in one cycle are independent; all three take effect on the same edge.
- No arithmetic, saturation or sign handling: words are opaque DATA_W bits.

Decomposition:
- Package pid_regfile_pkg holds:
  - ADDR_ZERO = 0.
  - EXT_BASE = 1.
  - Function gp_base(NUM_EXT) returning NUM_EXT+1.
  - Function is_gp(addr, NUM_EXT, NUM_GP).
  - Default PID register indices: TEMP1=0, IK=1, YK1=2, IK1=3, TEMP2=4, DK=5, PK=6, PWM=7.
- Sub-module pid_reg: DATA_W register with synchronous active-low reset and enable. Instantiated for GP registers, shadows and the PWM buffer.

Test Plan:
- Reset then read addresses 0..15 on both ports -> all 0; pwm_out=0, pwm_valid=0, wr_err=0.
- ext_in={18'h00200,18'h00100}, pulse sample -> next cycle addr1 reads 18'h00100 and addr2 reads 18'h00200. In the sample cycle itself, addr1 reads 0.
- Write 18'h3FFFF to addr 5 with rd_addr_a=5 in the same cycle:
  - BYPASS=1 -> rd_data_a=18'h3FFFF that cycle.
  - BYPASS=0 -> rd_data_a=0 that cycle and 18'h3FFFF the next.
- Write 18'h01234 to addr 10, then pulse commit -> pwm_out=18'h01234, pwm_valid=1. Next, write 18'h00055 to addr 10 with commit in the same cycle -> pwm_out stays 18'h01234; the following commit gives 18'h00055.
- Write 18'h00AAA to addrs 0, 1 and 12 -> wr_err pulses one cycle after each write; reads of 0/1/12 are unchanged (0, shadow, 0).
- Load GP0..GP7 with distinct values, drive rst=0 for one edge in the same cycle as wr_en, sample and commit -> all registers 0, pwm_valid=0, no wr_err.

Source files
------------

// File: rtl/pid_regfile_pkg.sv
// Shared constants and address-map helpers for the PID register bank.
package pid_regfile_pkg;

    // Fixed address-map anchors
    localparam int unsigned ADDR_ZERO = 0;
    localparam int unsigned EXT_BASE  = 1;

    // Default PID general-purpose register indices (0-based GP index)
    localparam int unsigned REG_TEMP1 = 0;
    localparam int unsigned REG_IK    = 1;
    localparam int unsigned REG_YK1   = 2;
    localparam int unsigned REG_IK1   = 3;
    localparam int unsigned REG_TEMP2 = 4;
    localparam int unsigned REG_DK    = 5;
    localparam int unsigned REG_PK    = 6;
    localparam int unsigned REG_PWM   = 7;

    // First address of the GP window, directly after the external shadows
    function automatic int unsigned gp_base(input int unsigned num_ext);
        return num_ext + EXT_BASE;
    endfunction

    // True when addr falls inside the writable GP window
    function automatic logic is_gp(input int unsigned addr,
                                   input int unsigned num_ext,
                                   input int unsigned num_gp);
        return (addr >= gp_base(num_ext)) && (addr < gp_base(num_ext) + num_gp);
    endfunction

endpackage

// File: rtl/pid_reg.sv
// Single word register with synchronous active-low reset and load enable.
module pid_reg #(
    parameter int unsigned DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q;

    // Clear on reset, otherwise load when enabled
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pid_regfile.sv
// PID register bank: GP registers, sampled external shadows, double-buffered PWM word.
module pid_regfile
    import pid_regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = 18,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned NUM_EXT = 2,
    parameter int unsigned NUM_GP  = 8,
    parameter int unsigned PWM_IDX = REG_PWM,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_EXT*DATA_W-1:0] ext_in,
    input  logic                      sample,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [ADDR_W-1:0]         rd_addr_a,
    input  logic [ADDR_W-1:0]         rd_addr_b,
    output logic [DATA_W-1:0]         rd_data_a,
    output logic [DATA_W-1:0]         rd_data_b,
    input  logic                      commit,
    output logic [DATA_W-1:0]         pwm_out,
    output logic                      pwm_valid,
    output logic                      wr_err
);

    localparam int unsigned GP_BASE = gp_base(NUM_EXT);

    // Reject parameter sets whose map does not fit the address space
    generate
        if (NUM_EXT + NUM_GP + 1 > 2 ** ADDR_W) begin : g_bad_map
            $fatal(1, "pid_regfile: address map does not fit in ADDR_W bits");
        end
        if (PWM_IDX >= NUM_GP) begin : g_bad_pwm
            $fatal(1, "pid_regfile: PWM_IDX outside GP range");
        end
    endgenerate

    logic [DATA_W-1:0] shadow_q [NUM_EXT];
    logic [DATA_W-1:0] gp_q     [NUM_GP];
    logic [DATA_W-1:0] pwm_q;
    logic              pwm_valid_q;
    logic              wr_err_q;
    logic              wr_gp;

    assign wr_gp = is_gp(32'(wr_addr), NUM_EXT, NUM_GP);

    genvar g;
    generate
        for (g = 0; g < NUM_GP; g++) begin : g_gp
            logic gp_en;
            assign gp_en = wr_en && (wr_addr == ADDR_W'(GP_BASE + g));
            pid_reg #(.DATA_W(DATA_W)) u_gp (
                .clk (clk),
                .rst (rst),
                .en  (gp_en),
                .d   (wr_data),
                .q   (gp_q[g])
            );
        end
        for (g = 0; g < NUM_EXT; g++) begin : g_shadow
            pid_reg #(.DATA_W(DATA_W)) u_shadow (
                .clk (clk),
                .rst (rst),
                .en  (sample),
                .d   (ext_in[g*DATA_W +: DATA_W]),
                .q   (shadow_q[g])
            );
        end
    endgenerate

    // Commit copies the registered (pre-edge) PWM source, never the write data
    pid_reg #(.DATA_W(DATA_W)) u_pwm (
        .clk (clk),
        .rst (rst),
        .en  (commit),
        .d   (gp_q[PWM_IDX]),
        .q   (pwm_q)
    );

    // Decode one read address against the registered state, with optional GP bypass
    function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = '0;
        if (a != ADDR_W'(ADDR_ZERO)) begin
            for (int k = 0; k < int'(NUM_EXT); k++) begin
                if (a == ADDR_W'(EXT_BASE + k)) r = shadow_q[k];
            end
            for (int k = 0; k < int'(NUM_GP); k++) begin
                if (a == ADDR_W'(GP_BASE + k)) r = gp_q[k];
            end
        end
        if ((BYPASS != 0) && wr_en && wr_gp && (a == wr_addr)) r = wr_data;
        return r;
    endfunction

    // Two independent combinational read ports
    always_comb begin
        rd_data_a = read_mux(rd_addr_a);
        rd_data_b = read_mux(rd_addr_b);
    end

    // Sticky valid flag and one-cycle error pulse for dropped writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_valid_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            wr_err_q <= wr_en && !wr_gp;
            if (commit) pwm_valid_q <= 1'b1;
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_valid = pwm_valid_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_pid_regfile.sv
// Randomized and directed check of pid_regfile against an address-map model.
module tb_pid_regfile;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int NE = 2;
    localparam int NG = 8;
    localparam int PWM_GP = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NE*DW-1:0] ext_in;
    logic             sample, wr_en, commit;
    logic [AW-1:0]    wr_addr, rd_addr_a, rd_addr_b;
    logic [DW-1:0]    wr_data;

    logic [DW-1:0] rda1, rdb1, pwm1;
    logic          val1, err1;
    logic [DW-1:0] rda0, rdb0, pwm0;
    logic          val0, err0;

    pid_regfile #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ext_in(ext_in), .sample(sample),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda1), .rd_data_b(rdb1),
        .commit(commit), .pwm_out(pwm1), .pwm_valid(val1), .wr_err(err1)
    );

    pid_regfile #(.BYPASS(0)) dut_nobyp (
        .clk(clk), .rst(rst), .ext_in(ext_in), .sample(sample),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda0), .rd_data_b(rdb0),
        .commit(commit), .pwm_out(pwm0), .pwm_valid(val0), .wr_err(err0)
    );

    // Model state: plain arrays indexed by GP number and ext channel
    logic [DW-1:0] m_gp [NG];
    logic [DW-1:0] m_sh [NE];
    logic [DW-1:0] m_pwm;
    logic          m_valid, m_err;

    int passed = 0;
    int total  = 0;

    function automatic bit in_gp(input int a);
        return (a >= NE + 1) && (a <= NE + NG);
    endfunction

    function automatic logic [DW-1:0] ref_read(input int a, input bit byp);
        if (byp && wr_en && in_gp(a) && a == int'(wr_addr)) return wr_data;
        if (a >= 1 && a <= NE) return m_sh[a-1];
        if (in_gp(a)) return m_gp[a-NE-1];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Compare every output of both instances against the model
    task automatic check_all(input string tag);
        #1;
        chk({tag, ".rd_a"},   rda1, ref_read(int'(rd_addr_a), 1'b1));
        chk({tag, ".rd_b"},   rdb1, ref_read(int'(rd_addr_b), 1'b1));
        chk({tag, ".rd_a0"},  rda0, ref_read(int'(rd_addr_a), 1'b0));
        chk({tag, ".rd_b0"},  rdb0, ref_read(int'(rd_addr_b), 1'b0));
        chk({tag, ".pwm"},    pwm1, m_pwm);
        chk({tag, ".pwm0"},   pwm0, m_pwm);
        chk({tag, ".valid"},  DW'(val1), DW'(m_valid));
        chk({tag, ".valid0"}, DW'(val0), DW'(m_valid));
        chk({tag, ".err"},    DW'(err1), DW'(m_err));
        chk({tag, ".err0"},   DW'(err0), DW'(m_err));
    endtask

    // Advance model with the current inputs, then let the DUT see the same edge
    task automatic step();
        logic [DW-1:0] old_pwm_src;
        if (!rst) begin
            for (int i = 0; i < NG; i++) m_gp[i] = '0;
            for (int i = 0; i < NE; i++) m_sh[i] = '0;
            m_pwm = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            old_pwm_src = m_gp[PWM_GP];
            m_err = wr_en && !in_gp(int'(wr_addr));
            if (wr_en && in_gp(int'(wr_addr))) m_gp[int'(wr_addr)-NE-1] = wr_data;
            if (sample) for (int i = 0; i < NE; i++) m_sh[i] = ext_in[i*DW +: DW];
            if (commit) begin
                m_pwm = old_pwm_src;
                m_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; wr_en = 1'b0; sample = 1'b0; commit = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    endtask

    initial begin
        ext_in = '0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
        idle();
        for (int i = 0; i < NG; i++) m_gp[i] = 'x;
        for (int i = 0; i < NE; i++) m_sh[i] = 'x;
        @(negedge clk);

        // Reset, then sweep the whole address map on both ports
        rst = 1'b0;
        step();
        idle();
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = AW'(a);
            rd_addr_b = AW'(15 - a);
            check_all("reset_map");
            step();
        end

        // Sample: old shadow visible in the sample cycle, new one afterwards
        ext_in = {18'h00200, 18'h00100};
        sample = 1'b1;
        rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        check_all("sample_same");
        chk("sample_same_lit", rda1, 18'h0);
        step();
        idle();
        ext_in = '0;
        check_all("sample_next");
        chk("sample_a1", rda1, 18'h00100);
        chk("sample_a2", rdb1, 18'h00200);

        // Bypass on a GP write
        do_write(5, 18'h3FFFF);
        rd_addr_a = 4'd5; rd_addr_b = 4'd0;
        check_all("bypass_same");
        chk("bypass_lit", rda1, 18'h3FFFF);
        chk("nobypass_lit", rda0, 18'h0);
        step();
        idle();
        check_all("bypass_next");
        chk("nobypass_next_lit", rda0, 18'h3FFFF);

        // Commit double buffering
        do_write(10, 18'h01234);
        step();
        idle();
        commit = 1'b1;
        step();
        idle();
        check_all("commit1");
        chk("commit1_lit", pwm1, 18'h01234);
        do_write(10, 18'h00055);
        commit = 1'b1;
        step();
        idle();
        check_all("commit_wr_same");
        chk("commit_hold_lit", pwm1, 18'h01234);
        commit = 1'b1;
        step();
        idle();
        check_all("commit2");
        chk("commit2_lit", pwm1, 18'h00055);

        // Dropped writes to constant, ext and unmapped addresses
        for (int k = 0; k < 3; k++) begin
            int a;
            a = (k == 0) ? 0 : (k == 1) ? 1 : 12;
            do_write(a, 18'h00AAA);
            rd_addr_a = AW'(a); rd_addr_b = AW'(a);
            step();
            idle();
            check_all("wr_err_pulse");
            chk("wr_err_lit", DW'(err1), 18'h1);
            step();
            check_all("wr_err_clear");
        end

        // Random mix of all inputs, with occasional resets
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) != 0);
            wr_en     = $urandom_range(0, 1) == 1;
            wr_addr   = AW'($urandom_range(0, 15));
            wr_data   = DW'($urandom);
            sample    = $urandom_range(0, 3) == 0;
            commit    = $urandom_range(0, 3) == 0;
            ext_in    = {DW'($urandom), DW'($urandom)};
            rd_addr_a = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, 15));
            rd_addr_b = AW'($urandom_range(0, 15));
            check_all("rand_pre");
            step();
        end
        idle();

        // Reset overrides simultaneous write, sample and commit
        for (int g = 0; g < NG; g++) begin
            do_write(NE + 1 + g, DW'(18'h10 + g));
            step();
        end
        idle();
        commit = 1'b1;
        step();
        rst = 1'b0; do_write(12, 18'h1); sample = 1'b1; commit = 1'b1;
        ext_in = {18'h3, 18'h4};
        step();
        idle();
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = AW'(a);
            rd_addr_b = AW'(a);
            check_all("rst_override");
            chk("rst_override_lit", rda1, 18'h0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
